counter_sequencer: RTL and testbench

- Control block that owns and sequences a WIDTH-bit up-counter for timer use.
- Provides start/stop/pause control, a programmable prescaler, a programmable terminal value, and one-shot or periodic operation.
- Sits between a host/control FSM and logic that needs timed events.
- Replaces free-running counters wherever a bounded, controllable count is required.

---
 rtl/counter_sequencer_if.sv | 27 ++
 rtl/counter_sequencer.sv | 101 ++++++++++
 tb/tb_counter_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Host-side control and status bundle for counter_sequencer.
// The master drives run commands; the slave (the sequencer) returns count and event pulses.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] term_val;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             done;
  logic             busy;

  modport master (
    output start, stop, pause, periodic, term_val, prescale,
    input  count, tick, done, busy
  );

  modport slave (
    input  start, stop, pause, periodic, term_val, prescale,
    output count, tick, done, busy
  );
endinterface

// File: rtl/counter_sequencer.sv
// Sequenced WIDTH-bit timer counter with prescaler, terminal value, pause and one-shot/periodic modes.
// Command priority each edge is stop > start > pause.
module counter_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 4
) (
  input logic                clk,
  input logic                rst,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic [PRE_W-1:0]   p_q, p_d;
  logic               per_q, per_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      pre_q   <= '0;
      term_q  <= '0;
      p_q     <= '0;
      per_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      term_q  <= term_d;
      p_q     <= p_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    term_d  = term_q;
    p_d     = p_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (bus.stop) begin
      state_d = StIdle;
      count_d = '0;
      pre_d   = '0;
    end else if (bus.start) begin
      // Restart from any state; holding start keeps the count pinned at 0.
      state_d = StRun;
      count_d = '0;
      pre_d   = '0;
      term_d  = bus.term_val;
      p_d     = bus.prescale;
      per_d   = bus.periodic;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.pause) begin
            state_d = StPaused;
          end else if (pre_q == p_q) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (count_q == term_q) begin
              done_d = 1'b1;
              if (per_q) count_d = '0;
              else       state_d = StDone;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        StPaused: begin
          if (!bus.pause) state_d = StRun;
        end
        StIdle: ;
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q == StRun) || (state_q == StPaused);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer with WIDTH=4, PRE_W=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_counter_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  counter_sequencer_if #(.WIDTH(4), .PRE_W(4)) bus ();

  counter_sequencer #(.WIDTH(4), .PRE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one sampling edge with the given run settings.
  task automatic arm(input logic [3:0] t, input logic [3:0] p, input logic per);
    bus.term_val = t;
    bus.prescale = p;
    bus.periodic = per;
    bus.start    = 1'b1;
    cyc(1);
    bus.start    = 1'b0;
  endtask

  task automatic status(input string tag, input int cnt, input logic tk, input logic dn,
                        input logic bsy);
    check({tag, "_count"}, 32'(bus.count), 32'(cnt));
    check({tag, "_tick"},  32'(bus.tick),  32'(tk));
    check({tag, "_done"},  32'(bus.done),  32'(dn));
    check({tag, "_busy"},  32'(bus.busy),  32'(bsy));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.periodic = 1'b0;
    bus.term_val = '0;
    bus.prescale = '0;

    cyc(2);
    status("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    bus.pause = 1'b1;
    cyc(3);
    status("idle_no_start", 0, 1'b0, 1'b0, 1'b0);
    bus.pause = 1'b0;

    // One-shot, term=5, P=0.
    arm(4'd5, 4'd0, 1'b0);
    status("os_armed", 0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      status("os_step", k, 1'b1, 1'b0, 1'b1);
    end
    cyc(1);
    status("os_term", 5, 1'b1, 1'b1, 1'b0);
    cyc(1);
    status("os_after", 5, 1'b0, 1'b0, 1'b0);
    bus.pause = 1'b1;
    cyc(2);
    status("os_hold", 5, 1'b0, 1'b0, 1'b0);
    bus.pause = 1'b0;

    // Periodic, term=3, P=2: tick every 3 edges, terminal every 12.
    arm(4'd3, 4'd2, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      cyc(1);
      status("per", (i / 3) % 4, 1'((i % 3) == 0), 1'((i % 12) == 0), 1'b1);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    status("per_stop", 0, 1'b0, 1'b0, 1'b0);

    // Pause at count 6, then run on to term=15 without wrap.
    arm(4'd15, 4'd0, 1'b0);
    cyc(6);
    status("pz_pre", 6, 1'b1, 1'b0, 1'b1);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      status("pz_hold", 6, 1'b0, 1'b0, 1'b1);
    end
    bus.pause = 1'b0;
    cyc(1);
    status("pz_resume", 6, 1'b0, 1'b0, 1'b1);
    for (int k = 7; k <= 15; k++) begin
      cyc(1);
      status("pz_run", k, 1'b1, 1'b0, 1'b1);
    end
    cyc(1);
    status("max_term", 15, 1'b1, 1'b1, 1'b0);

    // stop wins over start.
    arm(4'd9, 4'd0, 1'b0);
    cyc(7);
    status("pri_pre", 7, 1'b1, 1'b0, 1'b1);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    status("pri_stop", 0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    status("pri_idle", 0, 1'b0, 1'b0, 1'b0);

    // Restart mid-run latches the new terminal value.
    arm(4'd9, 4'd0, 1'b0);
    cyc(7);
    arm(4'd2, 4'd0, 1'b0);
    bus.term_val = 4'd9;
    status("rs_restart", 0, 1'b0, 1'b0, 1'b1);
    cyc(2);
    status("rs_two", 2, 1'b1, 1'b0, 1'b1);
    cyc(1);
    status("rs_term", 2, 1'b1, 1'b1, 1'b0);

    // term=0 periodic: every tick is terminal.
    arm(4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      status("t0", 0, 1'b1, 1'b1, 1'b1);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    status("t0_stop", 0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run.
    arm(4'd9, 4'd0, 1'b0);
    cyc(5);
    status("rst_pre", 5, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    status("rst_async", 0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    rst = 1'b1;
    cyc(3);
    status("rst_after", 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
